// File: rtl/analyzer_pkg.sv
// rtl/analyzer_pkg.sv - shared types and constants for the analyzer response path
package analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    SEND_CSUM
  } encoder_states;

  localparam int OPCODE_WIDTH           = 8;
  localparam int PAYLOAD_WIDTH          = 32;
  localparam int FRAME_WIDTH            = OPCODE_WIDTH + PAYLOAD_WIDTH;
  localparam int DEFAULT_NUM_DATA_BYTES = 4;
  localparam int FRAME_SLOTS            = DEFAULT_NUM_DATA_BYTES + 1;

  // Byte slots in a frame (opcode plus payload), excluding any checksum byte.
  function automatic int frame_slots(input int num_data_bytes);
    return num_data_bytes + 1;
  endfunction

endpackage

// File: rtl/response_encoder.sv
// rtl/response_encoder.sv - serializes {opcode, payload} into a byte stream
// Optional trailing XOR checksum byte: define RESPONSE_CHECKSUM_EN.
module response_encoder
  import analyzer_pkg::*;
#(
  parameter int NUM_DATA_BYTES = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rsp_valid,
  input  logic [OPCODE_WIDTH-1:0]  rsp_opcode,
  input  logic [PAYLOAD_WIDTH-1:0] rsp_data,
  output logic                     rsp_ready,
  output logic                     rsp_done,
  output logic [7:0]               byte_out,
  output logic                     byte_out_valid,
  input  logic                     byte_out_ready
);

  localparam logic [2:0] FRAME_COUNT = 3'(frame_slots(NUM_DATA_BYTES));

  encoder_states          state, state_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   transfer;
  logic                   ready_d, done_d, valid_d;
  logic [7:0]             byte_d;
`ifdef RESPONSE_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  assign transfer = byte_out_valid && byte_out_ready;

  // Every output is a flop loaded from the next-state values, so no input reaches an output combinationally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      shift_q        <= '0;
      cnt_q          <= '0;
      rsp_ready      <= 1'b1;
      rsp_done       <= 1'b0;
      byte_out       <= 8'h00;
      byte_out_valid <= 1'b0;
`ifdef RESPONSE_CHECKSUM_EN
      csum_q         <= 8'h00;
`endif
    end else begin
      state          <= state_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      rsp_ready      <= ready_d;
      rsp_done       <= done_d;
      byte_out       <= byte_d;
      byte_out_valid <= valid_d;
`ifdef RESPONSE_CHECKSUM_EN
      csum_q         <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef RESPONSE_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state)
      IDLE: begin
        if (rsp_valid && rsp_ready) begin
          shift_d = {rsp_opcode, rsp_data};
          cnt_d   = FRAME_COUNT;
`ifdef RESPONSE_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q - 3'd1;
`ifdef RESPONSE_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[FRAME_WIDTH-1 -: 8];
          if (cnt_q == 3'd1) state_d = SEND_CSUM;
`else
          if (cnt_q == 3'd1) state_d = IDLE;
`endif
        end
      end
`ifdef RESPONSE_CHECKSUM_EN
      SEND_CSUM: begin
        if (transfer) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == IDLE);
    valid_d = (state_d != IDLE);
    done_d  = (state != IDLE) && (state_d == IDLE);
    byte_d  = 8'h00;
    case (state_d)
      SEND:      byte_d = shift_d[FRAME_WIDTH-1 -: 8];
`ifdef RESPONSE_CHECKSUM_EN
      SEND_CSUM: byte_d = csum_d;
`endif
      default:   byte_d = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_response_encoder.sv
// tb/tb_response_encoder.sv - scoreboard bench for response_encoder
module tb_response_encoder;

  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rsp_valid;
  logic [7:0]  rsp_opcode;
  logic [31:0] rsp_data;
  logic        rsp_ready, rsp_done;
  logic [7:0]  byte_out;
  logic        byte_out_valid;
  logic        byte_out_ready;

  logic        r1_valid;
  logic [7:0]  r1_opcode;
  logic [31:0] r1_data;
  logic        r1_ready, r1_done;
  logic [7:0]  b1;
  logic        b1_valid;
  logic        b1_ready;

  response_encoder #(.NUM_DATA_BYTES(NB)) dut (
    .clock(clock), .reset_n(reset_n),
    .rsp_valid(rsp_valid), .rsp_opcode(rsp_opcode), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .rsp_done(rsp_done),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready)
  );

  response_encoder #(.NUM_DATA_BYTES(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .rsp_valid(r1_valid), .rsp_opcode(r1_opcode), .rsp_data(r1_data),
    .rsp_ready(r1_ready), .rsp_done(r1_done),
    .byte_out(b1), .byte_out_valid(b1_valid), .byte_out_ready(b1_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t exp_q[$];
  bit   pending_done = 0;
  bit   rand_ready   = 0;
  int   checks       = 0;
  int   passes       = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference frame: opcode, then payload bytes high to low, then optional XOR of all of them.
  task automatic push_frame(input logic [7:0] op, input logic [31:0] data, input int nbytes);
    logic [7:0] x;
    logic [7:0] b;
    x = op;
    exp_q.push_back('{op, 1'b0});
    for (int i = 0; i < nbytes; i++) begin
      b = 8'((data >> (8 * (3 - i))) & 32'hFF);
      x = x ^ b;
      exp_q.push_back('{b, 1'b0});
    end
`ifdef RESPONSE_CHECKSUM_EN
    exp_q.push_back('{x, 1'b0});
`endif
    exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] data);
    bit acc;
    bit done_ok;
    done_ok = 0;
    @(posedge clock); #1;
    rsp_opcode = op;
    rsp_data   = data;
    rsp_valid  = 1'b1;
    for (int c = 0; c < 200 && !done_ok; c++) begin
      @(negedge clock);
      acc = rsp_ready;
      @(posedge clock);
      if (acc) begin
        push_frame(op, data, NB);
        done_ok = 1;
      end
    end
    if (!done_ok) check("accept_timeout", 0, 1);
    #1;
    rsp_valid  = 1'b0;
    rsp_opcode = 8'($urandom);
    rsp_data   = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0 && !pending_done) ok = 1;
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clock); #1;
  endtask

  // Monitor: compares the DUT against the scoreboard every cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      check("rsp_ready", rsp_ready, exp_q.size() == 0);
      check("byte_out_valid", byte_out_valid, exp_q.size() != 0);
      check("rsp_done", rsp_done, pending_done);
      if (byte_out_valid && exp_q.size() != 0) check("byte_out", byte_out, exp_q[0].b);
      pending_done = 0;
      if (byte_out_valid && byte_out_ready && exp_q.size() != 0) begin
        pending_done = exp_q[0].last;
        void'(exp_q.pop_front());
      end
    end
  end

  always begin
    @(posedge clock); #1;
    if (rand_ready) byte_out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    reset_n = 1'b0;
    rsp_valid = 0; rsp_opcode = 0; rsp_data = 0; byte_out_ready = 1;
    r1_valid = 0; r1_opcode = 0; r1_data = 0; b1_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_rsp_ready", rsp_ready, 1);
    check("reset_rsp_done", rsp_done, 0);
    check("reset_valid", byte_out_valid, 0);
    check("reset_byte", byte_out, 8'h00);
    reset_n = 1'b1;

    // Basic frame
    send(8'hA5, 32'h12345678);
    wait_idle();

    // Transmitter stall while 34 is presented
    send(8'hA5, 32'h12345678);
    @(posedge clock);
    @(posedge clock); #1;
    byte_out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("stall_hold_byte", byte_out, 8'h34);
    check("stall_hold_valid", byte_out_valid, 1);
    byte_out_ready = 1'b1;
    wait_idle();

    // Request arriving while busy waits until the encoder is idle again
    send(8'hC3, 32'h11223344);
    send(8'h5A, 32'hDEADBEEF);
    wait_idle();

    // Reset mid-frame after byte 12 has gone
    send(8'h77, 32'h12345678);
    @(posedge clock);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", byte_out_valid, 0);
    check("midreset_byte", byte_out, 8'h00);
    check("midreset_ready", rsp_ready, 1);
    check("midreset_done", rsp_done, 0);
    exp_q.delete();
    pending_done = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    send(8'h01, 32'h0);
    wait_idle();

    // Short payload on the one-byte instance
    @(posedge clock); #1;
    r1_valid = 1; r1_opcode = 8'h03; r1_data = 32'hAB000000;
    @(posedge clock); #1;
    r1_valid = 0; r1_opcode = 8'hFF; r1_data = 32'hFFFFFFFF;
    check("short_b0", {b1_valid, b1}, {1'b1, 8'h03});
    check("short_ready_busy", r1_ready, 0);
    @(posedge clock); #1;
    check("short_b1", {b1_valid, b1}, {1'b1, 8'hAB});
`ifdef RESPONSE_CHECKSUM_EN
    @(posedge clock); #1;
    check("short_csum", {b1_valid, b1}, {1'b1, 8'hA8});
`endif
    @(posedge clock); #1;
    check("short_end_valid", b1_valid, 0);
    check("short_done", {r1_done, r1_ready}, 2'b11);
    @(posedge clock); #1;
    check("short_done_clear", r1_done, 0);

    // Randomized frames with random transmitter backpressure
    rand_ready = 1;
    for (int f = 0; f < 30; f++) begin
      send(8'($urandom), $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end
    wait_idle();
    rand_ready = 0;
    byte_out_ready = 1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
